// File: rtl/minterm_extractor_if.sv
// Minterm index stream from the extractor to its consumer.
// valid/idx flow master->slave and ready flows back.
interface minterm_extractor_if #(
  parameter int N_IN = 4
);
  logic            minterm_valid;
  logic [N_IN-1:0] minterm_idx;
  logic            minterm_ready;

  modport master (output minterm_valid, output minterm_idx, input minterm_ready);
  modport slave  (input minterm_valid, input minterm_idx, output minterm_ready);
endinterface

// File: rtl/minterm_extractor.sv
// Truth-table extractor: sweeps every input combination, samples f_in after a
// settle interval, then streams the minterm indices in ascending order.
module minterm_extractor #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        abcd,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   truth,
  output logic [N_IN:0]          count,
  minterm_extractor_if.master    mt
);

  localparam int NCOMB = 1 << N_IN;
  localparam int WW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WW-1:0] SETTLE_W = WW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_EMIT,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [NCOMB-1:0]   truth_q, truth_d;
  logic [N_IN:0]      count_q, count_d;
  logic [N_IN-1:0]    ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      truth_q <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      truth_q <= truth_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    truth_d = truth_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          wait_d  = '0;
          truth_d = '0;
          count_d = '0;
        end
      end
      S_SWEEP: begin
        if (wait_q != SETTLE_W) begin
          wait_d = wait_q + 1'b1;
        end else begin
          truth_d[idx_q] = f_in;
          count_d        = count_q + (N_IN+1)'(f_in);
          wait_d         = '0;
          if (idx_q == '1) begin
            state_d = S_EMIT;
            ptr_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_EMIT: begin
        // Zero entries are skipped in one cycle; ones wait for the handshake.
        if (!truth_q[ptr_q] || mt.minterm_ready) begin
          if (ptr_q == '1) state_d = S_FIN;
          else             ptr_d   = ptr_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        idx_d   = '0;
        ptr_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // abcd is the sweep index register itself; it is cleared on return to IDLE.
  assign abcd             = idx_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign truth            = truth_q;
  assign count            = count_q;
  assign mt.minterm_valid = (state_q == S_EMIT) && truth_q[ptr_q];
  assign mt.minterm_idx   = ptr_q;

endmodule

// File: tb/tb_minterm_extractor.sv
// Directed bench for minterm_extractor: reference/constant functions,
// backpressure, start rules, async reset mid-run and settle behaviour.
module tb_minterm_extractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start_s;
  logic [1:0]  fmode;

  logic [3:0]  abcd;
  logic        f_in;
  logic        busy, done;
  logic [15:0] truth;
  logic [4:0]  count;

  logic [3:0]  abcd3, abcd0;
  logic        f3, f0;
  logic        busy3, done3, busy0, done0;
  logic [15:0] truth3, truth0;
  logic [4:0]  count3, count0;
  logic [2:0]  dl3, dl0;

  int n_cmp;
  int n_err;
  logic [15:0] prev_truth;

  minterm_extractor_if #(.N_IN(4)) mt_i ();
  minterm_extractor_if #(.N_IN(4)) mt3 ();
  minterm_extractor_if #(.N_IN(4)) mt0 ();

  minterm_extractor #(.N_IN(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abcd(abcd), .f_in(f_in),
    .busy(busy), .done(done), .truth(truth), .count(count), .mt(mt_i.master)
  );

  minterm_extractor #(.N_IN(4), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abcd(abcd3), .f_in(f3),
    .busy(busy3), .done(done3), .truth(truth3), .count(count3), .mt(mt3.master)
  );

  minterm_extractor #(.N_IN(4), .SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abcd(abcd0), .f_in(f0),
    .busy(busy0), .done(done0), .truth(truth0), .count(count0), .mt(mt0.master)
  );

  assign mt3.minterm_ready = 1'b1;
  assign mt0.minterm_ready = 1'b1;

  // a = abcd[3]; f = b.c.d | a.~c.~d, or constant 0 / 1
  always_comb begin
    case (fmode)
      2'd0:    f_in = (abcd[2] & abcd[1] & abcd[0]) | (abcd[3] & ~abcd[1] & ~abcd[0]);
      2'd1:    f_in = 1'b0;
      default: f_in = 1'b1;
    endcase
  end

  // Function under test whose output lags abcd[0] by three registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl3 <= '0;
      dl0 <= '0;
    end else begin
      dl3 <= {dl3[1:0], abcd3[0]};
      dl0 <= {dl0[1:0], abcd0[0]};
    end
  end
  assign f3 = dl3[2];
  assign f0 = dl0[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_main(input string tag, input logic [15:0] exp_truth,
                          input logic [4:0] exp_cnt, input int stall_idx,
                          input int exp_done_edge, input bit poke);
    int got[$];
    int exp_l[$];
    int e;
    int done_e;
    int stall_left;
    int held;
    e = 0;
    done_e = -1;
    stall_left = 3;
    held = 0;
    for (int i = 0; i < 16; i++) if (exp_truth[i]) exp_l.push_back(i);

    chk({tag, ":prev_truth_held"}, 32'(truth), 32'(prev_truth));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, ":truth_cleared"}, 32'(truth), 32'd0);
    chk({tag, ":count_cleared"}, 32'(count), 32'd0);

    for (int cyc = 0; cyc < 300; cyc++) begin
      mt_i.minterm_ready = 1'b1;
      if (mt_i.minterm_valid && (int'(mt_i.minterm_idx) == stall_idx)) begin
        held++;
        if (stall_left > 0) begin
          mt_i.minterm_ready = 1'b0;
          stall_left--;
        end
      end
      if (mt_i.minterm_valid && mt_i.minterm_ready) got.push_back(int'(mt_i.minterm_idx));
      if (poke && e == 10) start = 1'b1;
      tick();
      e++;
      start = 1'b0;
      if (done) begin
        done_e = e;
        break;
      end
    end
    mt_i.minterm_ready = 1'b1;

    chk({tag, ":done_edge"}, 32'(done_e), 32'(exp_done_edge));
    chk({tag, ":busy_in_fin"}, 32'(busy), 32'd1);
    chk({tag, ":truth"}, 32'(truth), 32'(exp_truth));
    chk({tag, ":count"}, 32'(count), 32'(exp_cnt));
    chk({tag, ":n_minterms"}, 32'(got.size()), 32'(exp_l.size()));
    for (int i = 0; i < exp_l.size() && i < got.size(); i++)
      chk($sformatf("%s:minterm[%0d]", tag, i), 32'(got[i]), 32'(exp_l[i]));
    if (stall_idx >= 0) chk({tag, ":stall_hold"}, 32'(held), 32'd4);

    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ":idle_abcd"}, 32'(abcd), 32'd0);
    prev_truth = exp_truth;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold5;
    int done_seen;
    int n;
    n_cmp = 0;
    n_err = 0;
    prev_truth = '0;
    rst_n = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    fmode = 2'd0;
    mt_i.minterm_ready = 1'b1;
    repeat (2) tick();
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:truth", 32'(truth), 32'd0);
    chk("rst:count", 32'(count), 32'd0);
    chk("rst:abcd", 32'(abcd), 32'd0);
    chk("rst:valid", 32'(mt_i.minterm_valid), 32'd0);
    chk("rst:idx", 32'(mt_i.minterm_idx), 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    run_main("ref", 16'h9180, 5'd4, -1, 48, 1'b0);
    run_main("bp", 16'h9180, 5'd4, 8, 51, 1'b0);
    fmode = 2'd1;
    run_main("zero", 16'h0000, 5'd0, -1, 48, 1'b0);
    fmode = 2'd2;
    run_main("ones", 16'hFFFF, 5'd16, -1, 48, 1'b1);

    // SETTLE=3 sees the delayed function correctly; SETTLE=0 samples stale data.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    hold5 = 0;
    n = 0;
    while (!done3 && n < 300) begin
      if (abcd3 == 4'd5) hold5++;
      tick();
      n++;
    end
    chk("s3:done_seen", 32'(done3), 32'd1);
    chk("s3:hold_len", 32'(hold5), 32'd4);
    chk("s3:truth", 32'(truth3), 32'hAAAA);
    chk("s3:count", 32'(count3), 32'd8);
    chk("s0:truth_stale", 32'(truth0), 32'h5550);
    chk("s0:count", 32'(count0), 32'd6);
    repeat (2) tick();

    // Async reset in the middle of a sweep.
    fmode = 2'd2;
    chk("mid:prev_truth_held", 32'(truth), 32'hFFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (abcd != 4'd5 && n < 100) begin
      tick();
      n++;
    end
    chk("mid:reached_idx5", 32'(abcd), 32'd5);
    chk("mid:partial_truth", 32'(truth), 32'h001F);
    chk("mid:partial_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid:busy", 32'(busy), 32'd0);
    chk("mid:truth", 32'(truth), 32'd0);
    chk("mid:count", 32'(count), 32'd0);
    chk("mid:abcd", 32'(abcd), 32'd0);
    chk("mid:valid", 32'(mt_i.minterm_valid), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen = 1;
    end
    chk("mid:no_done", 32'(done_seen), 32'd0);
    chk("mid:still_idle", 32'(busy), 32'd0);
    prev_truth = '0;
    fmode = 2'd0;
    run_main("post_rst", 16'h9180, 5'd4, -1, 48, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/minterm_extractor.md
# minterm_extractor

Sequential truth-table extractor: the inverse of a minterm (sum-of-products) evaluator. On `start` it sweeps every input combination onto `abcd`, waits a settle interval, samples the single-bit function output `f_in`, and builds the function's truth table. It then streams the minterm indices in ascending order over a valid/ready handshake. It sits next to any combinational minterm circuit in the lab designs and recovers that circuit's minterm list in hardware.

## Interface
- `N_IN`, default 4: number of function inputs; the sweep covers 2^N_IN combinations.
- `SETTLE`, default 1, minimum 0: extra cycles each combination is held before `f_in` is sampled.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  begins an extraction; sampled only in IDLE.
- `abcd`  out  N_IN  drive to the function under test, MSB = a.
- `f_in`  in  1  function output returned from the function under test.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of extraction.
- `truth`  out  2^N_IN  bit i = sampled f_in for input i.
- `count`  out  N_IN+1  number of ones in `truth`.
- `minterm_valid`  out  1  a minterm index is presented.
- `minterm_idx`  out  N_IN  index being presented.
- `minterm_ready`  in  1  consumer accepts the index.

## Operation
- **States:** IDLE, SWEEP, EMIT, FIN. All state is registered.
- **Reset (async, any state):** state=IDLE, abcd=0, truth=0, count=0, busy=0, done=0, minterm_valid=0, minterm_idx=0, internal idx/wait/ptr=0. Reset mid-sweep or mid-emit abandons the run; no done pulse is generated.
- **IDLE:** abcd=0.
  - start=1 → SWEEP with idx=0, wait=0, truth=0, count=0.
  - truth and count from the previous run hold until that edge.
- **SWEEP:** abcd=idx.
  - While wait<SETTLE: wait++.
  - On the edge where wait==SETTLE: truth[idx]<=f_in, count<=count+f_in, wait<=0.
  - After that sample: if idx==2^N_IN-1 → EMIT with ptr=0; otherwise idx++.
  - Each combination is held exactly SETTLE+1 cycles.
- **EMIT:** abcd holds the last combination.
  - minterm_valid = truth[ptr] (combinational from registered state); minterm_idx=ptr.
  - ptr advances when truth[ptr]==0 (skip, one cycle) or when valid&&ready.
  - With valid=1 and ready=0: ptr, minterm_idx and valid hold stable. The handshake never drops an offered index.
  - Advancing from ptr==2^N_IN-1 → FIN.
- **FIN:** done=1 for this one cycle → IDLE.
- **start:** ignored while busy. A start asserted in the FIN cycle is also ignored; it must be re-asserted in IDLE.
- **count width:** N_IN+1 bits. count=2^N_IN (all ones) is representable without wrap.
- **Zero-minterm function:** EMIT never asserts valid and takes 2^N_IN cycles. done still pulses.
- **f_in sampling:** f_in is sampled only on the sample edge. Glitches during the settle cycles are irrelevant.

## Timing
- Edge 0 samples start. busy rises after edge 0.
- SWEEP lasts 2^N_IN*(SETTLE+1) cycles.
- EMIT lasts 2^N_IN cycles plus one cycle per ready=0 stall on a valid index.
- done is high for the single cycle after EMIT ends. busy is low in the following cycle.
- N_IN=4, SETTLE=1, ready tied high:
  - SWEEP occupies edges 1–32.
  - EMIT occupies edges 33–48.
  - done is high between edges 48 and 49.
  - Total: 49 cycles from start to IDLE.
- Outputs are glitch-free registers except minterm_valid, which is a registered-state decode with no input path.

## Test plan
- **Reference function f=b·c·d | a·¬c·¬d** (N_IN=4, SETTLE=1, ready=1, start at edge 0) → truth=0x9180, count=4. Indices 7, 8, 12, 15 are presented in that order, one per valid cycle. done registers on edge 48 and is high for one cycle.
- **Backpressure:** same function, ready=0 for 3 cycles whenever idx 8 is presented → minterm_idx stays at 8 for 4 cycles with valid=1. No index is lost or duplicated. done is delayed by exactly 3 cycles.
- **Constant functions:**
  - f=0 → truth=0, count=0, valid never asserts, done at edge 48.
  - f=1 → truth=0xFFFF, count=16, indices 0–15 presented.
- **Settle:** SETTLE=3, f_in=abcd[0] delayed by 3 cycles via a registered model → truth=0xAAAA. A bench with SETTLE=0 against the same delayed model shows mismatch, which proves the settle count is honoured. Each abcd value is held 4 cycles.
- **Start rules:** start pulsed during SWEEP and during FIN → no restart, run completes normally. start re-asserted in IDLE → a new run begins, clearing truth and count on that edge.
- **Reset mid-run:** rst_n low asynchronously during SWEEP at idx=5 → immediately state IDLE, truth=0, count=0, abcd=0, busy=0, no done pulse. After rst_n high, a new start produces a correct full run.
